// File: rtl/connect_n_engine.sv
`default_nettype none
// ============================================================================
// Module      : connect_n_engine
// Description : Parametrised Connect-N game core. Accepts column-drop
//               requests (rising edge of enable, active-low column select),
//               drops the mover's token into the lowest free cell, then walks
//               eight rays one cell per cycle from the placed cell to detect a
//               run of WIN_LEN. It reports the board, owners, column heights,
//               game status and the cells of any winning run.
// Ports       : clk, reset (async, active-high)
//               enable            - drop request, rising edge detected here
//               in_column         - active-low one-hot column select
//               out_gameboard     - occupancy, bit r*COLS+c, row 0 = bottom
//               out_players_cells - owner per cell (0 = P1, 1 = P2)
//               out_game_status   - 00 playing, 01 P1 won, 10 P2 won, 11 tie
//               current_state     - FSM state encoding
//               playerTurn        - 0 = P1 to move, 1 = P2 to move
//               column_heights    - HW-bit token count per column
//               busy              - high in PLACE/CHECK/RESULT
//               illegal           - one-cycle pulse on a rejected request
//               win_cells         - cells of the winning run(s)
// Revision    : 1.0 - initial release
// ============================================================================
module connect_n_engine #(
  parameter int COLS    = 4,
  parameter int ROWS    = 4,
  parameter int WIN_LEN = 4,
  parameter int HW      = $clog2(ROWS + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [COLS-1:0]      in_column,
  output logic [ROWS*COLS-1:0] out_gameboard,
  output logic [ROWS*COLS-1:0] out_players_cells,
  output logic [1:0]           out_game_status,
  output logic [2:0]           current_state,
  output logic                 playerTurn,
  output logic [COLS*HW-1:0]   column_heights,
  output logic                 busy,
  output logic                 illegal,
  output logic [ROWS*COLS-1:0] win_cells
);

  localparam int NCELL = ROWS * COLS;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_PLACE  = 3'd1,
    S_CHECK  = 3'd2,
    S_RESULT = 3'd3,
    S_OVER   = 3'd4
  } state_t;

  // Signed coordinate wide enough for a ray stepping off either board edge.
  typedef logic signed [4:0] coord_t;

  state_t           r_state;
  logic             r_enable_q;
  logic [HW-1:0]    r_height [COLS];
  logic [2:0]       r_col;
  logic [2:0]       r_row;
  logic [2:0]       r_ray;
  logic [2:0]       r_step;
  coord_t           r_pos_c;
  coord_t           r_pos_r;
  logic             r_alive;
  logic [2:0]       r_cnt;
  logic [2:0]       r_first_cnt;
  logic [NCELL-1:0] r_mask;
  logic [NCELL-1:0] r_first_mask;
  logic             r_win;

  logic             w_req;
  logic [3:0]       w_nlow;
  logic [2:0]       w_pick;
  logic [HW-1:0]    w_pick_h;
  logic             w_valid;
  logic             w_full;
  logic [NCELL-1:0] w_place_mask;
  logic [NCELL-1:0] w_pos_mask;
  logic             w_hit;
  logic [2:0]       w_cnt_n;
  logic [NCELL-1:0] w_mask_n;
  logic [3:0]       w_total;
  logic             w_ray_end;

  // Ray order: (+1,0) (-1,0) (0,+1) (0,-1) (+1,+1) (-1,-1) (+1,-1) (-1,+1).
  // Even/odd rays form the opposite halves of one direction.
  function automatic coord_t ray_dc(input logic [2:0] ray);
    case (ray)
      3'd0, 3'd4, 3'd6: ray_dc = 5'sd1;
      3'd1, 3'd5, 3'd7: ray_dc = -5'sd1;
      default:          ray_dc = 5'sd0;
    endcase
  endfunction

  function automatic coord_t ray_dr(input logic [2:0] ray);
    case (ray)
      3'd2, 3'd4, 3'd7: ray_dr = 5'sd1;
      3'd3, 3'd5, 3'd6: ray_dr = -5'sd1;
      default:          ray_dr = 5'sd0;
    endcase
  endfunction

  assign w_req         = enable & ~r_enable_q;
  assign current_state = r_state;

  for (genvar c = 0; c < COLS; c++) begin : g_heights
    assign column_heights[c*HW +: HW] = r_height[c];
  end

  // Request decode: count low select bits and find the selected column.
  always_comb begin
    w_nlow   = '0;
    w_pick   = '0;
    w_pick_h = '0;
    w_full   = 1'b1;
    for (int c = 0; c < COLS; c++) begin
      if (!in_column[c]) begin
        w_nlow = w_nlow + 4'd1;
        w_pick = 3'(c);
      end
    end
    for (int c = 0; c < COLS; c++) begin
      if (w_pick == 3'(c)) w_pick_h = r_height[c];
      if (r_height[c] != HW'(ROWS)) w_full = 1'b0;
    end
    w_valid = (w_nlow == 4'd1) && (w_pick_h < HW'(ROWS));
  end

  // One-hot cell vectors for the placed cell and the current ray position.
  // An off-board ray position matches no cell, so it reads as a miss.
  always_comb begin
    w_place_mask = '0;
    w_pos_mask   = '0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        if (r_row == 3'(r) && r_col == 3'(c)) w_place_mask[r*COLS+c] = 1'b1;
        if (r_pos_r == coord_t'(r) && r_pos_c == coord_t'(c)) w_pos_mask[r*COLS+c] = 1'b1;
      end
    end
    w_hit = r_alive &&
            (|(w_pos_mask & out_gameboard & ~(out_players_cells ^ {NCELL{playerTurn}})));
    w_cnt_n   = r_cnt + {2'b00, w_hit};
    w_mask_n  = r_mask | (w_hit ? w_pos_mask : '0);
    w_total   = 4'd1 + {1'b0, r_first_cnt} + {1'b0, w_cnt_n};
    w_ray_end = (r_step == 3'(WIN_LEN - 2));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state           <= S_IDLE;
      r_enable_q        <= 1'b0;
      r_col             <= '0;
      r_row             <= '0;
      r_ray             <= '0;
      r_step            <= '0;
      r_pos_c           <= '0;
      r_pos_r           <= '0;
      r_alive           <= 1'b0;
      r_cnt             <= '0;
      r_first_cnt       <= '0;
      r_mask            <= '0;
      r_first_mask      <= '0;
      r_win             <= 1'b0;
      out_gameboard     <= '0;
      out_players_cells <= '0;
      out_game_status   <= 2'b00;
      playerTurn        <= 1'b0;
      busy              <= 1'b0;
      illegal           <= 1'b0;
      win_cells         <= '0;
      for (int c = 0; c < COLS; c++) r_height[c] <= '0;
    end else begin
      r_enable_q <= enable;
      illegal    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            if (w_valid) begin
              r_col   <= w_pick;
              r_row   <= 3'(w_pick_h);
              busy    <= 1'b1;
              r_state <= S_PLACE;
            end else begin
              illegal <= 1'b1;
            end
          end
        end

        S_PLACE: begin
          out_gameboard <= out_gameboard | w_place_mask;
          if (playerTurn) out_players_cells <= out_players_cells | w_place_mask;
          for (int c = 0; c < COLS; c++) begin
            if (r_col == 3'(c)) r_height[c] <= r_height[c] + 1'b1;
          end
          r_ray   <= 3'd0;
          r_step  <= 3'd0;
          r_alive <= 1'b1;
          r_cnt   <= '0;
          r_mask  <= '0;
          r_win   <= 1'b0;
          r_pos_c <= coord_t'(r_col) + ray_dc(3'd0);
          r_pos_r <= coord_t'(r_row) + ray_dr(3'd0);
          r_state <= S_CHECK;
        end

        S_CHECK: begin
          if (w_hit) begin
            r_pos_c <= r_pos_c + ray_dc(r_ray);
            r_pos_r <= r_pos_r + ray_dr(r_ray);
          end else begin
            r_alive <= 1'b0;
          end
          if (!w_ray_end) begin
            r_step <= r_step + 3'd1;
            r_cnt  <= w_cnt_n;
            r_mask <= w_mask_n;
          end else begin
            // First half of a direction is parked; the second half closes it.
            if (!r_ray[0]) begin
              r_first_cnt  <= w_cnt_n;
              r_first_mask <= w_mask_n;
            end else if (w_total >= 4'(WIN_LEN)) begin
              r_win     <= 1'b1;
              win_cells <= win_cells | r_first_mask | w_mask_n | w_place_mask;
            end
            r_step  <= 3'd0;
            r_cnt   <= '0;
            r_mask  <= '0;
            r_alive <= 1'b1;
            r_ray   <= r_ray + 3'd1;
            r_pos_c <= coord_t'(r_col) + ray_dc(r_ray + 3'd1);
            r_pos_r <= coord_t'(r_row) + ray_dr(r_ray + 3'd1);
            if (r_ray == 3'd7) r_state <= S_RESULT;
          end
        end

        S_RESULT: begin
          busy <= 1'b0;
          if (r_win) begin
            out_game_status <= playerTurn ? 2'b10 : 2'b01;
            r_state         <= S_OVER;
          end else if (w_full) begin
            out_game_status <= 2'b11;
            r_state         <= S_OVER;
          end else begin
            playerTurn <= ~playerTurn;
            r_state    <= S_IDLE;
          end
        end

        S_OVER: begin
          r_state <= S_OVER;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_connect_n_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_connect_n_engine
// Description : Self-checking bench for connect_n_engine. DUT a uses the
//               default 4x4 / connect-4 configuration and is driven from a
//               table of drops with hand-computed results; DUT b is a 5x4
//               connect-3 board used for latency and busy-request sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_connect_n_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT a : 4x4, WIN_LEN 4 ----------------
  logic        rst_a, en_a;
  logic [3:0]  col_a;
  logic [15:0] board_a, own_a, win_a;
  logic [1:0]  st_a;
  logic [2:0]  state_a;
  logic        turn_a, busy_a, ill_a;
  logic [11:0] hts_a;

  connect_n_engine dut_a (
    .clk(clk), .reset(rst_a), .enable(en_a), .in_column(col_a),
    .out_gameboard(board_a), .out_players_cells(own_a), .out_game_status(st_a),
    .current_state(state_a), .playerTurn(turn_a), .column_heights(hts_a),
    .busy(busy_a), .illegal(ill_a), .win_cells(win_a)
  );

  // ---------------- DUT b : 5x4, WIN_LEN 3 ----------------
  logic        rst_b, en_b;
  logic [4:0]  col_b;
  logic [19:0] board_b, own_b, win_b;
  logic [1:0]  st_b;
  logic [2:0]  state_b;
  logic        turn_b, busy_b, ill_b;
  logic [14:0] hts_b;

  connect_n_engine #(.COLS(5), .ROWS(4), .WIN_LEN(3)) dut_b (
    .clk(clk), .reset(rst_b), .enable(en_b), .in_column(col_b),
    .out_gameboard(board_b), .out_players_cells(own_b), .out_game_status(st_b),
    .current_state(state_b), .playerTurn(turn_b), .column_heights(hts_b),
    .busy(busy_b), .illegal(ill_b), .win_cells(win_b)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        rst;
    logic [3:0]  col;
    logic        ill;
    logic [15:0] board;
    logic [15:0] own;
    logic [11:0] hts;
    logic [1:0]  st;
    logic        turn;
    logic [15:0] win;
    logic [2:0]  state;
    logic        full;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic rst, input logic [3:0] col, input logic ill,
                     input logic [15:0] board, input logic [15:0] own,
                     input logic [11:0] hts, input logic [1:0] st, input logic turn,
                     input logic [15:0] win, input logic [2:0] state, input logic full);
    vec_t v;
    v.rst = rst; v.col = col; v.ill = ill; v.board = board; v.own = own;
    v.hts = hts; v.st = st; v.turn = turn; v.win = win; v.state = state; v.full = full;
    vq.push_back(v);
  endtask

  task automatic reset_a();
    rst_a = 1'b1;
    repeat (2) @(negedge clk);
    rst_a = 1'b0;
  endtask

  task automatic wait_idle_a();
    int n = 0;
    while (busy_a && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("a_busy_timeout", {31'd0, busy_a}, 32'd0);
  endtask

  task automatic wait_idle_b();
    int n = 0;
    while (busy_b && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("b_busy_timeout", {31'd0, busy_b}, 32'd0);
  endtask

  task automatic drop_b(input int c);
    @(negedge clk);
    col_b = ~(5'b00001 << c);
    en_b  = 1'b1;
    @(negedge clk);
    en_b  = 1'b0;
    col_b = 5'b11111;
    wait_idle_b();
  endtask

  task automatic req_a(input logic [3:0] col);
    @(negedge clk);
    col_a = col;
    en_a  = 1'b1;
    @(negedge clk);
    en_a  = 1'b0;
    col_a = 4'b1111;
  endtask

  initial begin
    int tie_cols[16] = '{0, 2, 2, 0, 0, 2, 2, 0, 1, 3, 3, 1, 1, 3, 3, 1};
    logic [3:0] m;

    // Vertical P1 win in column 0, then a request while in OVER.
    add(1, 4'b1110, 0, 16'h0001, 16'h0000, 12'h001, 2'd0, 1, 16'h0000, 3'd0, 1);
    add(0, 4'b1101, 0, 16'h0003, 16'h0002, 12'h009, 2'd0, 0, 16'h0000, 3'd0, 1);
    add(0, 4'b1110, 0, 16'h0013, 16'h0002, 12'h00A, 2'd0, 1, 16'h0000, 3'd0, 1);
    add(0, 4'b1011, 0, 16'h0017, 16'h0006, 12'h04A, 2'd0, 0, 16'h0000, 3'd0, 1);
    add(0, 4'b1110, 0, 16'h0117, 16'h0006, 12'h04B, 2'd0, 1, 16'h0000, 3'd0, 1);
    add(0, 4'b1011, 0, 16'h0157, 16'h0046, 12'h08B, 2'd0, 0, 16'h0000, 3'd0, 1);
    add(0, 4'b1110, 0, 16'h1157, 16'h0046, 12'h08C, 2'd1, 0, 16'h1111, 3'd4, 1);
    add(0, 4'b1101, 0, 16'h1157, 16'h0046, 12'h08C, 2'd1, 0, 16'h1111, 3'd4, 1);
    // Horizontal P2 win across row 1.
    add(1, 4'b1110, 0, 16'h0001, 16'h0000, 12'h001, 2'd0, 1, 16'h0000, 3'd0, 1);
    add(0, 4'b1110, 0, 16'h0011, 16'h0010, 12'h002, 2'd0, 0, 16'h0000, 3'd0, 1);
    add(0, 4'b1101, 0, 16'h0013, 16'h0010, 12'h00A, 2'd0, 1, 16'h0000, 3'd0, 1);
    add(0, 4'b1101, 0, 16'h0033, 16'h0030, 12'h012, 2'd0, 0, 16'h0000, 3'd0, 1);
    add(0, 4'b0111, 0, 16'h003B, 16'h0030, 12'h212, 2'd0, 1, 16'h0000, 3'd0, 1);
    add(0, 4'b1011, 0, 16'h003F, 16'h0034, 12'h252, 2'd0, 0, 16'h0000, 3'd0, 1);
    add(0, 4'b1110, 0, 16'h013F, 16'h0034, 12'h253, 2'd0, 1, 16'h0000, 3'd0, 1);
    add(0, 4'b1011, 0, 16'h017F, 16'h0074, 12'h293, 2'd0, 0, 16'h0000, 3'd0, 1);
    add(0, 4'b1101, 0, 16'h037F, 16'h0074, 12'h29B, 2'd0, 1, 16'h0000, 3'd0, 1);
    add(0, 4'b0111, 0, 16'h03FF, 16'h00F4, 12'h49B, 2'd2, 1, 16'h00F0, 3'd4, 1);
    // Full column and malformed selects are rejected without a turn change.
    add(1, 4'b1110, 0, 16'h0001, 16'h0000, 12'h001, 2'd0, 1, 16'h0000, 3'd0, 1);
    add(0, 4'b1110, 0, 16'h0011, 16'h0010, 12'h002, 2'd0, 0, 16'h0000, 3'd0, 1);
    add(0, 4'b1110, 0, 16'h0111, 16'h0010, 12'h003, 2'd0, 1, 16'h0000, 3'd0, 1);
    add(0, 4'b1110, 0, 16'h1111, 16'h1010, 12'h004, 2'd0, 0, 16'h0000, 3'd0, 1);
    add(0, 4'b1110, 1, 16'h1111, 16'h1010, 12'h004, 2'd0, 0, 16'h0000, 3'd0, 1);
    add(0, 4'b1100, 1, 16'h1111, 16'h1010, 12'h004, 2'd0, 0, 16'h0000, 3'd0, 1);
    add(0, 4'b1111, 1, 16'h1111, 16'h1010, 12'h004, 2'd0, 0, 16'h0000, 3'd0, 1);
    add(0, 4'b1101, 0, 16'h1113, 16'h1010, 12'h00C, 2'd0, 1, 16'h0000, 3'd0, 1);
    // 16-drop tie: columns 0,1 alternate P1/P2 bottom-up, columns 2,3 P2/P1.
    for (int i = 0; i < 16; i++) begin
      m = 4'b0001 << tie_cols[i];
      if (i < 15)
        add(i == 0, ~m, 0, 16'h0, 16'h0, 12'h0, 2'd0, 0, 16'h0, 3'd0, 0);
      else
        add(0, ~m, 0, 16'hFFFF, 16'h3C3C, 12'h924, 2'd3, 1, 16'h0000, 3'd4, 1);
    end

    rst_a = 1'b1; en_a = 1'b0; col_a = 4'b1111;
    rst_b = 1'b1; en_b = 1'b0; col_b = 5'b11111;
    repeat (3) @(negedge clk);
    rst_a = 1'b0;
    rst_b = 1'b0;
    @(negedge clk);

    chk("reset_board", {16'd0, board_a}, 32'd0);
    chk("reset_owner", {16'd0, own_a}, 32'd0);
    chk("reset_status", {30'd0, st_a}, 32'd0);
    chk("reset_state", {29'd0, state_a}, 32'd0);
    chk("reset_turn", {31'd0, turn_a}, 32'd0);
    chk("reset_heights", {20'd0, hts_a}, 32'd0);
    chk("reset_busy", {31'd0, busy_a}, 32'd0);
    chk("reset_win", {16'd0, win_a}, 32'd0);

    foreach (vq[i]) begin
      if (vq[i].rst) reset_a();
      @(negedge clk);
      col_a = vq[i].col;
      en_a  = 1'b1;
      @(negedge clk);
      chk($sformatf("v%0d_illegal", i), {31'd0, ill_a}, {31'd0, vq[i].ill});
      en_a  = 1'b0;
      col_a = 4'b1111;
      @(negedge clk);
      chk($sformatf("v%0d_illegal_end", i), {31'd0, ill_a}, 32'd0);
      wait_idle_a();
      chk($sformatf("v%0d_status", i), {30'd0, st_a}, {30'd0, vq[i].st});
      if (vq[i].full) begin
        chk($sformatf("v%0d_board", i), {16'd0, board_a}, {16'd0, vq[i].board});
        chk($sformatf("v%0d_owner", i), {16'd0, own_a}, {16'd0, vq[i].own});
        chk($sformatf("v%0d_heights", i), {20'd0, hts_a}, {20'd0, vq[i].hts});
        chk($sformatf("v%0d_turn", i), {31'd0, turn_a}, {31'd0, vq[i].turn});
        chk($sformatf("v%0d_win", i), {16'd0, win_a}, {16'd0, vq[i].win});
        chk($sformatf("v%0d_state", i), {29'd0, state_a}, {29'd0, vq[i].state});
      end
    end

    // Enable held high for 40 cycles yields exactly one drop.
    reset_a();
    @(negedge clk);
    col_a = 4'b1110;
    en_a  = 1'b1;
    repeat (40) @(negedge clk);
    en_a  = 1'b0;
    col_a = 4'b1111;
    wait_idle_a();
    chk("hold_board", {16'd0, board_a}, 32'h0001);
    chk("hold_heights", {20'd0, hts_a}, 32'h001);
    chk("hold_turn", {31'd0, turn_a}, 32'd1);

    // Reset asserted mid-CHECK clears everything immediately.
    req_a(4'b1101);
    repeat (9) @(negedge clk);
    chk("midchk_state", {29'd0, state_a}, 32'd2);
    #2 rst_a = 1'b1;
    #1;
    chk("abort_board", {16'd0, board_a}, 32'd0);
    chk("abort_heights", {20'd0, hts_a}, 32'd0);
    chk("abort_turn", {31'd0, turn_a}, 32'd0);
    chk("abort_state", {29'd0, state_a}, 32'd0);
    chk("abort_busy", {31'd0, busy_a}, 32'd0);
    chk("abort_status", {30'd0, st_a}, 32'd0);
    @(negedge clk);
    rst_a = 1'b0;
    req_a(4'b1011);
    wait_idle_a();
    chk("after_abort_board", {16'd0, board_a}, 32'h0004);
    chk("after_abort_owner", {16'd0, own_a}, 32'h0000);
    chk("after_abort_turn", {31'd0, turn_a}, 32'd1);
    chk("after_abort_heights", {20'd0, hts_a}, 32'h040);

    // DUT b: rising diagonal (0,0),(1,1),(2,2) for P1 on a 5x4 connect-3.
    drop_b(0);
    drop_b(1);
    drop_b(1);
    drop_b(2);
    // Drop in column 4 with a second request issued while busy.
    @(negedge clk);
    col_b = 5'b01111;
    en_b  = 1'b1;
    @(negedge clk);
    en_b  = 1'b0;
    repeat (5) @(negedge clk);
    col_b = 5'b11110;
    en_b  = 1'b1;
    @(negedge clk);
    chk("b_busy_req_illegal", {31'd0, ill_b}, 32'd0);
    en_b  = 1'b0;
    col_b = 5'b11111;
    wait_idle_b();
    chk("b_busy_req_board", {12'd0, board_b}, 32'h00057);
    chk("b_busy_req_owner", {12'd0, own_b}, 32'h00006);
    chk("b_busy_req_turn", {31'd0, turn_b}, 32'd1);
    drop_b(2);
    // Winning drop: busy stays high through edge 18, status valid after edge 19.
    @(negedge clk);
    col_b = 5'b11011;
    en_b  = 1'b1;
    @(negedge clk);
    en_b  = 1'b0;
    col_b = 5'b11111;
    repeat (17) @(negedge clk);
    chk("b_latency_busy", {31'd0, busy_b}, 32'd1);
    chk("b_latency_status_early", {30'd0, st_b}, 32'd0);
    @(negedge clk);
    chk("b_latency_done", {31'd0, busy_b}, 32'd0);
    chk("b_status", {30'd0, st_b}, 32'd1);
    chk("b_win", {12'd0, win_b}, 32'h01041);
    chk("b_board", {12'd0, board_b}, 32'h010D7);
    chk("b_owner", {12'd0, own_b}, 32'h00086);
    chk("b_heights", {17'd0, hts_b}, 32'h10D1);
    chk("b_state", {29'd0, state_b}, 32'd4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
